// File: rtl/alu.sv
// Registered 32-bit ALU for the execute stage: result/zero (and optional overflow) one clock after operands.
// Optional feature macro: ALU_OVERFLOW_EN adds the registered signed-overflow output.
module alu (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  ALUcont,
`ifdef ALU_OVERFLOW_EN
    output logic        overflow,
`endif
    output logic [31:0] result,
    output logic        zero
);

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_RAND = 3'b100;
    localparam logic [2:0] ALU_ROR  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    logic [31:0] b_eff;
    logic [31:0] sum;
    logic        sum_ovf;
    logic        slt_bit;
    logic [31:0] next_result;
    logic        next_zero;

    // Bit 2 of the opcode selects inverted B; for SUB/SLT it also supplies the +1 carry-in.
    assign b_eff   = ALUcont[2] ? ~B : B;
    assign sum     = A + b_eff + {31'd0, ALUcont[2]};
    assign sum_ovf = (A[31] == b_eff[31]) && (sum[31] != A[31]);
    assign slt_bit = sum[31] ^ sum_ovf;

    always_comb begin
        next_result = 32'h0;
        case (ALUcont)
            ALU_AND:  next_result = A & B;
            ALU_OR:   next_result = A | B;
            ALU_ADD:  next_result = sum;
            ALU_RAND: next_result = A & b_eff;
            ALU_ROR:  next_result = A | b_eff;
            ALU_SUB:  next_result = sum;
            ALU_SLT:  next_result = {31'd0, slt_bit};
            default:  next_result = 32'h0;
        endcase
    end

    assign next_zero = (next_result == 32'h0);

    always_ff @(posedge clk) begin
        if (reset) begin
            result <= 32'h0;
            zero   <= 1'b1;
        end else begin
            result <= next_result;
            zero   <= next_zero;
        end
    end

`ifdef ALU_OVERFLOW_EN
    logic next_ovf;

    assign next_ovf = ((ALUcont == ALU_ADD) || (ALUcont == ALU_SUB)) && sum_ovf;

    always_ff @(posedge clk) begin
        if (reset) overflow <= 1'b0;
        else       overflow <= next_ovf;
    end
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors plus randomized operations against a behavioural model.
module tb_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  ALUcont;
    logic [31:0] result;
    logic        zero;
`ifdef ALU_OVERFLOW_EN
    logic        overflow;
`endif

    int errors = 0;
    int checks = 0;

    alu dut (
        .clk     (clk),
        .reset   (reset),
        .A       (A),
        .B       (B),
        .ALUcont (ALUcont),
`ifdef ALU_OVERFLOW_EN
        .overflow(overflow),
`endif
        .result  (result),
        .zero    (zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        longint sa;
        longint sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd4: return a & ~b;
            3'd5: return a | ~b;
            3'd6: return a - b;
            3'd7: return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        longint sa;
        longint sb;
        longint s;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (op == 3'd2)      s = sa + sb;
        else if (op == 3'd6) s = sa - sb;
        else                 return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Drive operands away from the edge, then land 1 ns after the next rising edge.
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        A = a;
        B = b;
        ALUcont = op;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        apply(32'd150, 32'd50, 3'd2);
        checks++;
        if (result !== 32'h0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL reset: result=%h zero=%b, expected result=0 zero=1", result, zero);
        end
`ifdef ALU_OVERFLOW_EN
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: overflow=%b, expected 0", overflow);
        end
`endif
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] va [0:15];
        logic [31:0] vb [0:15];
        logic [2:0]  vo [0:15];
        logic [31:0] ve [0:15];
        va[0]  = 150;           vb[0]  = 50;           vo[0]  = 3'b000; ve[0]  = 32'd18;
        va[1]  = 1;             vb[1]  = 2;            vo[1]  = 3'b001; ve[1]  = 32'd3;
        va[2]  = 10000;         vb[2]  = 32;           vo[2]  = 3'b010; ve[2]  = 32'd10032;
        va[3]  = 32'hFFFF_FFFF; vb[3]  = 1;            vo[3]  = 3'b010; ve[3]  = 32'd0;
        va[4]  = 1;             vb[4]  = 0;            vo[4]  = 3'b100; ve[4]  = 32'd1;
        va[5]  = 1;             vb[5]  = 0;            vo[5]  = 3'b101; ve[5]  = 32'hFFFF_FFFF;
        va[6]  = 100;           vb[6]  = 50;           vo[6]  = 3'b110; ve[6]  = 32'd50;
        va[7]  = 77;            vb[7]  = 77;           vo[7]  = 3'b110; ve[7]  = 32'd0;
        va[8]  = 123;           vb[8]  = 456;          vo[8]  = 3'b011; ve[8]  = 32'd0;
        va[9]  = 10;            vb[9]  = 5;            vo[9]  = 3'b111; ve[9]  = 32'd0;
        va[10] = 10;            vb[10] = 11;           vo[10] = 3'b111; ve[10] = 32'd1;
        va[11] = 32'hFFFF_FFFF; vb[11] = 0;            vo[11] = 3'b111; ve[11] = 32'd1;
        va[12] = 32'h8000_0000; vb[12] = 1;            vo[12] = 3'b111; ve[12] = 32'd1;
        va[13] = 1;             vb[13] = 32'h8000_0000; vo[13] = 3'b111; ve[13] = 32'd0;
        va[14] = 32'h7FFF_FFFF; vb[14] = 1;            vo[14] = 3'b010; ve[14] = 32'h8000_0000;
        va[15] = 32'h8000_0000; vb[15] = 1;            vo[15] = 3'b110; ve[15] = 32'h7FFF_FFFF;
        for (int i = 0; i < 16; i++) begin
            apply(va[i], vb[i], vo[i]);
            checks++;
            if (result !== ve[i] || zero !== (ve[i] == 32'd0)) begin
                errors++;
                $display("FAIL directed[%0d] op=%b: result=%h zero=%b, expected result=%h zero=%b",
                         i, vo[i], result, zero, ve[i], (ve[i] == 32'd0));
            end
        end
    endtask

    task automatic test_overflow();
`ifdef ALU_OVERFLOW_EN
        logic [31:0] va [0:3];
        logic [31:0] vb [0:3];
        logic [2:0]  vo [0:3];
        logic        ve [0:3];
        va[0] = 32'h7FFF_FFFF; vb[0] = 1; vo[0] = 3'b010; ve[0] = 1'b1;
        va[1] = 32'h8000_0000; vb[1] = 1; vo[1] = 3'b110; ve[1] = 1'b1;
        va[2] = 32'h8000_0000; vb[2] = 1; vo[2] = 3'b000; ve[2] = 1'b0;
        va[3] = 32'h8000_0000; vb[3] = 1; vo[3] = 3'b111; ve[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apply(va[i], vb[i], vo[i]);
            checks++;
            if (overflow !== ve[i]) begin
                errors++;
                $display("FAIL overflow[%0d] op=%b: overflow=%b, expected %b", i, vo[i], overflow, ve[i]);
            end
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] exp_r;
        for (int i = 0; i < 300; i++) begin
            a  = pick_operand();
            b  = ($urandom_range(0, 9) == 0) ? a : pick_operand();
            op = 3'($urandom_range(0, 7));
            exp_r = ref_result(a, b, op);
            apply(a, b, op);
            checks++;
            if (result !== exp_r || zero !== (exp_r == 32'd0)) begin
                errors++;
                $display("FAIL random[%0d] a=%h b=%h op=%b: result=%h zero=%b, expected result=%h zero=%b",
                         i, a, b, op, result, zero, exp_r, (exp_r == 32'd0));
            end
`ifdef ALU_OVERFLOW_EN
            checks++;
            if (overflow !== ref_ovf(a, b, op)) begin
                errors++;
                $display("FAIL random_ovf[%0d] a=%h b=%h op=%b: overflow=%b, expected %b",
                         i, a, b, op, overflow, ref_ovf(a, b, op));
            end
`endif
        end
    endtask

    task automatic test_hold_between_edges();
        apply(32'd40, 32'd2, 3'b010);
        A = 32'd0;
        B = 32'd0;
        ALUcont = 3'b011;
        #3;
        checks++;
        if (result !== 32'd42 || zero !== 1'b0) begin
            errors++;
            $display("FAIL hold: result=%h zero=%b, expected result=0000002a zero=0", result, zero);
        end
        @(posedge clk);
        #1;
        checks++;
        if (result !== 32'd0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL hold_next: result=%h zero=%b, expected result=0 zero=1", result, zero);
        end
    endtask

    task automatic test_reset_midstream();
        apply(32'd5, 32'd9, 3'b001);
        reset = 1'b1;
        apply(32'h7FFF_FFFF, 32'd1, 3'b010);
        checks++;
        if (result !== 32'h0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: result=%h zero=%b, expected result=0 zero=1", result, zero);
        end
`ifdef ALU_OVERFLOW_EN
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ovf: overflow=%b, expected 0", overflow);
        end
`endif
        reset = 1'b0;
        apply(32'd7, 32'd8, 3'b010);
        checks++;
        if (result !== 32'd15 || zero !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: result=%h zero=%b, expected result=0000000f zero=0", result, zero);
        end
    endtask

    initial begin
        reset   = 1'b1;
        A       = 32'h0;
        B       = 32'h0;
        ALUcont = 3'b000;
        #2;
        test_reset();
        test_directed();
        test_overflow();
        test_hold_between_edges();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
